// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// fifo_rd_drain : drains len words from a FIFO read port onto a valid/ready
//                 stream through a 2-entry skid buffer.   Rev 1.0
// ============================================================================
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic                  inflight;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] buf0, buf1;
  logic                  pop;
  logic                  start_ok;
  logic [1:0]            pending;

  assign start_ok = (state == IDLE) && start;
  assign m_valid  = (occ != 2'd0);
  assign m_data   = buf0;
  assign m_last   = m_valid && ((count + LEN_WIDTH'(1)) == len_q);
  assign pop      = m_valid && m_ready;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // Slots that will be occupied after this edge if no new read is issued;
  // never exceeds 3, so 2 bits suffice and the subtraction cannot underflow.
  assign pending    = occ + {1'b0, inflight} - {1'b0, pop};
  assign fifo_rd_en = (state == RUN) && !fifo_empty && (issued < len_q) &&
                      (pending < 2'd2);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (pop && m_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      issued   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      buf0     <= '0;
      buf1     <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;

      if (start_ok) begin
        len_q  <= len;
        issued <= '0;
        count  <= '0;
      end else begin
        if (fifo_rd_en) issued <= issued + LEN_WIDTH'(1);
        if (pop)        count  <= count + LEN_WIDTH'(1);
      end

      // Head is always buf0; a capture lands behind whatever survives the pop.
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_rdata;
          else             buf1 <= fifo_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_rdata;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_rdata;
          end
        end
        default: ;
      endcase

      if (fifo_underflow) err <= 1'b1;
      else if (start_ok)  err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// tb_fifo_rd_drain : randomized self-checking bench with a queue-based FIFO
//                    and stream reference model.   Rev 1.0
// ============================================================================
module tb_fifo_rd_drain;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          rd_clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          err;
  logic [LW-1:0] count;

  fifo_rd_drain #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .rd_clk         (rd_clk),
    .rst_n          (rst_n),
    .start          (start),
    .len            (len),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_rdata     (fifo_rdata),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .count          (count)
  );

  always #5 rd_clk = ~rd_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO contents and the words the current transfer should deliver, in order
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] ref_q[$];

  int   xfer_len, delivered, reads, cyc;
  int   first_hs_cyc, last_hs_cyc;
  bit   rand_ready;
  bit   prev_stall;
  logic [9:0] prev_word;

  logic          s_valid, s_rd_en, s_busy, s_done, s_err, s_last;
  logic [DW-1:0] s_data;
  logic [LW-1:0] s_count;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    ref_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample and check at the falling edge, then update the FIFO
  // model and stream stimulus just after the rising edge.
  task automatic cycle();
    bit hs, rd_now;
    cyc++;
    @(negedge rd_clk);
    s_valid = m_valid; s_rd_en = fifo_rd_en; s_busy = busy; s_done = done;
    s_err = err; s_last = m_last; s_data = m_data; s_count = count;
    check_eq("rd_en_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
    if (prev_stall) check_eq("stream_hold", {22'd0, m_valid, m_last, m_data}, {22'd0, prev_word});
    hs = m_valid && m_ready;
    if (hs) begin
      if (ref_q.size() == 0) begin
        check_eq("unexpected_word", 32'd1, 32'd0);
      end else begin
        check_eq("data", {24'd0, m_data}, {24'd0, ref_q.pop_front()});
      end
      check_eq("last", {31'd0, m_last}, {31'd0, (delivered + 1 == xfer_len)});
      if (delivered == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      delivered++;
    end
    rd_now = fifo_rd_en;
    if (rd_now) reads++;
    check_eq("outstanding_le2", {31'd0, (reads - delivered) <= 2}, 32'd1);
    prev_stall = m_valid && !m_ready && rst_n;
    prev_word  = {m_valid, m_last, m_data};
    @(posedge rd_clk);
    #1;
    if (rd_now && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len = LW'(l);
    ref_q = fifo_q;
    xfer_len = l; delivered = 0; reads = 0;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (s_done) return;
    end
    check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; fifo_empty = 1'b1;
    fifo_underflow = 1'b0; fifo_rdata = '0; m_ready = 1'b1;
    rand_ready = 1'b0; prev_stall = 1'b0; prev_word = '0;
    cyc = 0; xfer_len = 0; delivered = 0; reads = 0;
    first_hs_cyc = 0; last_hs_cyc = 0;

    cycle(); cycle();
    check_eq("rst_valid", {31'd0, s_valid}, 32'd0);
    check_eq("rst_rd_en", {31'd0, s_rd_en}, 32'd0);
    check_eq("rst_busy",  {31'd0, s_busy},  32'd0);
    check_eq("rst_done",  {31'd0, s_done},  32'd0);
    check_eq("rst_err",   {31'd0, s_err},   32'd0);
    check_eq("rst_count", {24'd0, s_count}, 32'd0);
    rst_n = 1'b1;
    cycle();

    // Full-rate drain of 16 words
    for (int i = 1; i <= 16; i++) push(DW'(i));
    do_start(16);
    cycle();
    check_eq("t1_rd_en_after_start", {31'd0, s_rd_en}, 32'd1);
    check_eq("t1_valid_early", {31'd0, s_valid}, 32'd0);
    cycle();
    check_eq("t1_valid_e1", {31'd0, s_valid}, 32'd0);
    cycle();
    check_eq("t1_valid_e2", {31'd0, s_valid}, 32'd1);
    check_eq("t1_first_data", {24'd0, s_data}, 32'h01);
    wait_done(60);
    check_eq("t1_delivered", delivered, 16);
    check_eq("t1_back_to_back", last_hs_cyc - first_hs_cyc, 15);
    check_eq("t1_done_latency", cyc - last_hs_cyc, 1);
    check_eq("t1_busy_at_done", {31'd0, s_busy}, 32'd0);
    check_eq("t1_count", {24'd0, s_count}, 32'd16);
    check_eq("t1_err", {31'd0, s_err}, 32'd0);
    cycle();
    check_eq("t1_done_pulse", {31'd0, s_done}, 32'd0);

    // Random back-pressure
    for (int i = 1; i <= 16; i++) push(DW'(i));
    rand_ready = 1'b1;
    do_start(16);
    wait_done(400);
    rand_ready = 1'b0;
    m_ready = 1'b1;
    check_eq("t2_delivered", delivered, 16);
    check_eq("t2_count", {24'd0, s_count}, 32'd16);
    check_eq("t2_leftover", ref_q.size(), 0);
    cycle();

    // FIFO runs dry mid-transfer
    for (int i = 0; i < 3; i++) push(DW'(8'h21 + i));
    do_start(5);
    for (int i = 0; i < 20; i++) cycle();
    check_eq("t3_stalled_delivered", delivered, 3);
    check_eq("t3_stalled_busy", {31'd0, s_busy}, 32'd1);
    push(8'h24); push(8'h25);
    wait_done(40);
    check_eq("t3_delivered", delivered, 5);
    check_eq("t3_count", {24'd0, s_count}, 32'd5);
    cycle();

    // Zero length, then a start ignored during RUN
    do_start(0);
    check_eq("t4_no_rd_en", {31'd0, s_rd_en}, 32'd0);
    cycle();
    check_eq("t4_done", {31'd0, s_done}, 32'd1);
    check_eq("t4_rd_en", {31'd0, s_rd_en}, 32'd0);
    check_eq("t4_count", {24'd0, s_count}, 32'd0);
    check_eq("t4_reads", reads, 0);
    cycle();
    for (int i = 0; i < 4; i++) push(DW'(8'h31 + i));
    m_ready = 1'b0;
    do_start(4);
    m_ready = 1'b0;
    cycle();
    m_ready = 1'b0;
    start = 1'b1; len = 8'd2;
    cycle();
    start = 1'b0;
    m_ready = 1'b1;
    wait_done(40);
    check_eq("t4_ignored_start", delivered, 4);
    check_eq("t4_count4", {24'd0, s_count}, 32'd4);
    cycle();

    // Underflow sets the sticky error
    for (int i = 0; i < 8; i++) push(DW'(8'h51 + i));
    do_start(8);
    cycle(); cycle();
    fifo_underflow = 1'b1;
    cycle();
    fifo_underflow = 1'b0;
    cycle();
    check_eq("t5_err_set", {31'd0, s_err}, 32'd1);
    wait_done(40);
    check_eq("t5_err_at_done", {31'd0, s_err}, 32'd1);
    cycle();
    check_eq("t5_err_sticky", {31'd0, s_err}, 32'd1);
    do_start(0);
    cycle();
    check_eq("t5_err_cleared", {31'd0, s_err}, 32'd0);
    cycle();

    // Reset mid-transfer with the skid buffer full
    for (int i = 0; i < 10; i++) push(DW'(8'h41 + i));
    m_ready = 1'b0;
    do_start(10);
    for (int i = 0; i < 5; i++) begin
      m_ready = 1'b0;
      cycle();
    end
    check_eq("t6_buffered", reads, 2);
    m_ready = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    m_ready = 1'b0;
    cycle();
    check_eq("t6_rst_valid", {31'd0, s_valid}, 32'd0);
    check_eq("t6_rst_rd_en", {31'd0, s_rd_en}, 32'd0);
    check_eq("t6_rst_busy",  {31'd0, s_busy},  32'd0);
    check_eq("t6_rst_done",  {31'd0, s_done},  32'd0);
    check_eq("t6_rst_last",  {31'd0, s_last},  32'd0);
    check_eq("t6_rst_data",  {24'd0, s_data},  32'd0);
    check_eq("t6_rst_count", {24'd0, s_count}, 32'd0);
    m_ready = 1'b1;
    do_start(4);
    wait_done(40);
    check_eq("t6_delivered", delivered, 4);
    check_eq("t6_fifo_left", fifo_q.size(), 4);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
